// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute per instruction,
// stalls on the memory ready handshake and traps on illegal opcodes or memory timeouts.
module mips_multicycle_ctrl #(
    parameter int unsigned OPCODE_W    = 6,
    parameter bit          BNE_EN      = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_wr_cond,
    output logic                branch_ne,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                fault,
    output logic [1:0]          fault_code,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'('h00);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'('h02);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'('h04);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'('h05);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'('h08);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'('h23);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'('h2B);

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       pc_write;
        logic       pc_wr_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    state_t            r_state;
    ctrl_t             r_ctrl;
    logic [WAIT_W-1:0] r_wait;
    logic              r_fault;
    logic [1:0]        r_fault_code;
    logic [CNT_W-1:0]  r_count;

    state_t w_next;
    logic   w_wait;
    logic   w_timeout;
    logic   w_illegal;
    logic   w_retire;
    logic   w_fetch_ack;

    // Moore control word for a state; registered from the next state so it aligns with r_state.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic is_bne);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'b01; end
            S_DECODE:   c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEM_RD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEM_WR:   begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.iord = 1'b1; end
            S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_EXEC_I:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_I_WB:     c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_op     = 2'b01;
                c.pc_wr_cond = 1'b1;
                c.pc_src     = 2'b01;
                c.branch_ne  = is_bne;
            end
            S_JUMP:     begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
            default:    ;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next    = r_state;
        w_wait    = 1'b0;
        w_timeout = 1'b0;
        w_illegal = 1'b0;
        w_retire  = 1'b0;
        case (r_state)
            S_RST:   w_next = S_FETCH;
            S_FETCH: if (mem_ready) w_next = S_DECODE; else w_wait = 1'b1;
            S_DECODE: begin
                case (opcode)
                    OP_R:           w_next = S_EXEC_R;
                    OP_LW, OP_SW:   w_next = S_MEM_ADDR;
                    OP_BEQ:         w_next = S_BRANCH;
                    OP_ADDI:        w_next = S_EXEC_I;
                    OP_J:           w_next = S_JUMP;
                    OP_BNE: begin
                        if (BNE_EN) w_next = S_BRANCH;
                        else begin w_next = S_TRAP; w_illegal = 1'b1; end
                    end
                    default: begin w_next = S_TRAP; w_illegal = 1'b1; end
                endcase
            end
            S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB; else w_wait = 1'b1;
            S_MEM_WR: begin
                if (mem_ready) begin w_next = S_FETCH; w_retire = 1'b1; end
                else w_wait = 1'b1;
            end
            S_EXEC_R: w_next = S_R_WB;
            S_EXEC_I: w_next = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_RST;
        endcase
        // A ready on the final allowed cycle is not a wait, so it completes instead of trapping.
        if (w_wait && (MEM_TIMEOUT != 0) && (r_wait == TIMEOUT_LAST)) begin
            w_next    = S_TRAP;
            w_timeout = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_RST;
            r_ctrl       <= '0;
            r_wait       <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
            r_count      <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode_ctrl(w_next, opcode == OP_BNE);
            r_wait  <= w_wait ? r_wait + WAIT_W'(1) : '0;
            if (w_illegal) begin
                r_fault      <= 1'b1;
                r_fault_code <= 2'b01;
            end
            if (w_timeout) begin
                r_fault      <= 1'b1;
                r_fault_code <= 2'b10;
            end
            if (w_retire) r_count <= r_count + CNT_W'(1);
        end
    end

    // IR load and PC increment complete in the same cycle memory returns the instruction.
    assign w_fetch_ack = (r_state == S_FETCH) && mem_ready;
    assign ir_write    = w_fetch_ack;
    assign pc_write    = r_ctrl.pc_write | w_fetch_ack;

    assign mem_req     = r_ctrl.mem_req;
    assign mem_we      = r_ctrl.mem_we;
    assign iord        = r_ctrl.iord;
    assign pc_wr_cond  = r_ctrl.pc_wr_cond;
    assign branch_ne   = r_ctrl.branch_ne;
    assign pc_src      = r_ctrl.pc_src;
    assign alu_src_a   = r_ctrl.alu_src_a;
    assign alu_src_b   = r_ctrl.alu_src_b;
    assign alu_op      = r_ctrl.alu_op;
    assign reg_write   = r_ctrl.reg_write;
    assign reg_dst     = r_ctrl.reg_dst;
    assign mem_to_reg  = r_ctrl.mem_to_reg;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign instr_count = r_count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: default instance plus a BNE_EN=0, CNT_W=4 instance.
module tb_mips_multicycle_ctrl;

    logic clk;
    logic rst, rst2;
    logic [5:0] opcode, opcode2;
    logic mem_ready, mem_ready2;

    logic d1_mem_req, d1_mem_we, d1_iord, d1_ir_write, d1_pc_write, d1_pc_wr_cond, d1_branch_ne;
    logic [1:0] d1_pc_src, d1_alu_src_b, d1_alu_op, d1_fault_code;
    logic d1_alu_src_a, d1_reg_write, d1_reg_dst, d1_mem_to_reg, d1_fault;
    logic [31:0] d1_count;

    logic d2_mem_req, d2_mem_we, d2_iord, d2_ir_write, d2_pc_write, d2_pc_wr_cond, d2_branch_ne;
    logic [1:0] d2_pc_src, d2_alu_src_b, d2_alu_op, d2_fault_code;
    logic d2_alu_src_a, d2_reg_write, d2_reg_dst, d2_mem_to_reg, d2_fault;
    logic [3:0] d2_count;

    int n_checks = 0;
    int n_fail   = 0;

    mips_multicycle_ctrl u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(d1_mem_req), .mem_we(d1_mem_we), .iord(d1_iord), .ir_write(d1_ir_write),
        .pc_write(d1_pc_write), .pc_wr_cond(d1_pc_wr_cond), .branch_ne(d1_branch_ne),
        .pc_src(d1_pc_src), .alu_src_a(d1_alu_src_a), .alu_src_b(d1_alu_src_b),
        .alu_op(d1_alu_op), .reg_write(d1_reg_write), .reg_dst(d1_reg_dst),
        .mem_to_reg(d1_mem_to_reg), .fault(d1_fault), .fault_code(d1_fault_code),
        .instr_count(d1_count)
    );

    mips_multicycle_ctrl #(.OPCODE_W(6), .BNE_EN(1'b0), .MEM_TIMEOUT(16), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst2), .opcode(opcode2), .mem_ready(mem_ready2),
        .mem_req(d2_mem_req), .mem_we(d2_mem_we), .iord(d2_iord), .ir_write(d2_ir_write),
        .pc_write(d2_pc_write), .pc_wr_cond(d2_pc_wr_cond), .branch_ne(d2_branch_ne),
        .pc_src(d2_pc_src), .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b),
        .alu_op(d2_alu_op), .reg_write(d2_reg_write), .reg_dst(d2_reg_dst),
        .mem_to_reg(d2_mem_to_reg), .fault(d2_fault), .fault_code(d2_fault_code),
        .instr_count(d2_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 2 time units after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Issue one instruction from FETCH and count cycles until FETCH is seen again.
    task automatic measure(input logic [5:0] op, input int exp_cycles, input string tag);
        int n;
        n = 0;
        opcode = op;
        do begin
            cyc(1);
            n++;
        end while (!(d1_mem_req && !d1_iord && d1_alu_src_b == 2'b01) && n < 20);
        chk(tag, 64'(n), 64'(exp_cycles));
    endtask

    logic [20:0] all_out;
    assign all_out = {d1_mem_req, d1_mem_we, d1_iord, d1_ir_write, d1_pc_write, d1_pc_wr_cond,
                      d1_branch_ne, d1_pc_src, d1_alu_src_a, d1_alu_src_b, d1_alu_op,
                      d1_reg_write, d1_reg_dst, d1_mem_to_reg, d1_fault, d1_fault_code};

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        opcode = 6'h00; opcode2 = 6'h00;
        mem_ready = 1'b1; mem_ready2 = 1'b1;

        // Reset state and the single RST cycle before FETCH
        cyc(2);
        chk("rst_outputs", 64'(all_out), 64'(0));
        chk("rst_count", 64'(d1_count), 64'(0));
        rst = 1'b0;
        #1;
        chk("rst_state_no_req", 64'(d1_mem_req), 64'(0));
        chk("rst_state_no_irw", 64'(d1_ir_write), 64'(0));
        cyc(1);
        chk("fetch_mem_req", 64'(d1_mem_req), 64'(1));
        chk("fetch_ir_write", 64'(d1_ir_write), 64'(1));
        chk("fetch_pc_write", 64'(d1_pc_write), 64'(1));
        chk("fetch_src_b", 64'(d1_alu_src_b), 64'(1));

        // Zero-wait latencies
        measure(6'h23, 5, "lat_lw");
        measure(6'h2B, 4, "lat_sw");
        measure(6'h00, 4, "lat_r");
        measure(6'h08, 4, "lat_addi");
        measure(6'h04, 3, "lat_beq");
        measure(6'h02, 3, "lat_j");
        chk("count_after_6", 64'(d1_count), 64'(6));

        // LW with three stalled MEM_RD cycles
        opcode = 6'h23;
        cyc(1);
        chk("dec_src_b", 64'(d1_alu_src_b), 64'(3));
        chk("dec_no_req", 64'(d1_mem_req), 64'(0));
        cyc(1);
        chk("maddr_srcs", 64'({d1_alu_src_a, d1_alu_src_b, d1_alu_op}), 64'(5'b1_10_00));
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("mrd_hold_req_iord", 64'({d1_mem_req, d1_iord, d1_reg_write}), 64'(3'b110));
        end
        mem_ready = 1'b1;
        cyc(1);
        chk("mwb_ctrl", 64'({d1_reg_write, d1_mem_to_reg, d1_reg_dst, d1_mem_req}), 64'(4'b1100));
        cyc(1);
        chk("lw_stall_count", 64'(d1_count), 64'(7));

        // BNE legal on the default instance
        opcode = 6'h05;
        cyc(2);
        chk("bne_branch", 64'({d1_branch_ne, d1_pc_wr_cond, d1_pc_src, d1_alu_op, d1_alu_src_a,
                               d1_alu_src_b}), 64'(9'b1_1_01_01_1_00));
        cyc(1);

        // R-type execute and writeback controls
        opcode = 6'h00;
        cyc(2);
        chk("exec_r", 64'({d1_alu_src_a, d1_alu_src_b, d1_alu_op}), 64'(5'b1_00_10));
        cyc(1);
        chk("r_wb", 64'({d1_reg_write, d1_reg_dst, d1_mem_to_reg}), 64'(3'b110));
        cyc(1);
        chk("count_after_r", 64'(d1_count), 64'(9));

        // Ready arriving on the sixteenth FETCH cycle wins over the timeout
        mem_ready = 1'b0;
        #1;
        chk("fetch_wait_no_irw", 64'(d1_ir_write), 64'(0));
        cyc(15);
        chk("fetch_cycle16_req", 64'(d1_mem_req), 64'(1));
        chk("fetch_cycle16_nofault", 64'(d1_fault), 64'(0));
        mem_ready = 1'b1;
        opcode = 6'h02;
        #1;
        chk("fetch_late_ack", 64'(d1_ir_write), 64'(1));
        cyc(1);
        chk("late_ack_decode", 64'({d1_fault, d1_alu_src_b}), 64'(3'b0_11));
        cyc(1);
        chk("jump_ctrl", 64'({d1_pc_write, d1_pc_src, d1_mem_req}), 64'(4'b1_10_0));
        cyc(1);
        chk("count_after_j", 64'(d1_count), 64'(10));

        // Sixteen waiting FETCH cycles trap with a timeout code
        mem_ready = 1'b0;
        cyc(15);
        chk("to_cycle16_req", 64'(d1_mem_req), 64'(1));
        chk("to_cycle16_nofault", 64'(d1_fault), 64'(0));
        cyc(1);
        chk("to_fault", 64'({d1_fault, d1_fault_code}), 64'(3'b1_10));
        chk("to_no_req", 64'(d1_mem_req), 64'(0));
        mem_ready = 1'b1;
        cyc(3);
        chk("trap_held", 64'(all_out), 64'(21'b1_10));
        chk("trap_count_frozen", 64'(d1_count), 64'(10));

        // Illegal opcode after a reset clears the sticky fault
        rst = 1'b1;
        #1;
        chk("rst_clears_fault", 64'({d1_fault, d1_fault_code}), 64'(0));
        chk("rst_clears_count", 64'(d1_count), 64'(0));
        rst = 1'b0;
        cyc(1);
        opcode = 6'h3F;
        cyc(2);
        chk("illegal_fault", 64'({d1_fault, d1_fault_code}), 64'(3'b1_01));
        chk("illegal_no_enables", 64'({d1_ir_write, d1_pc_write, d1_mem_req}), 64'(0));

        // Asynchronous reset in the middle of a stalled SW
        rst = 1'b1;
        #1;
        rst = 1'b0;
        cyc(1);
        opcode = 6'h2B;
        cyc(1);
        mem_ready = 1'b0;
        cyc(2);
        chk("mwr_ctrl", 64'({d1_mem_req, d1_mem_we, d1_iord}), 64'(3'b111));
        cyc(2);
        chk("mwr_hold", 64'({d1_mem_req, d1_mem_we, d1_iord}), 64'(3'b111));
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", 64'(all_out), 64'(0));
        cyc(1);
        chk("async_rst_held", 64'(all_out), 64'(0));
        rst = 1'b0;
        mem_ready = 1'b1;

        // 4-bit counter wraps: 17 jumps leave it at 1
        rst2 = 1'b0;
        cyc(1);
        chk("d2_fetch", 64'({d2_mem_req, d2_ir_write}), 64'(2'b11));
        chk("d2_count0", 64'(d2_count), 64'(0));
        opcode2 = 6'h02;
        for (int i = 1; i <= 17; i++) begin
            cyc(3);
            chk("d2_count_wrap", 64'(d2_count), 64'(i % 16));
        end

        // BNE is illegal when BNE_EN=0
        opcode2 = 6'h05;
        cyc(2);
        chk("d2_bne_illegal", 64'({d2_fault, d2_fault_code}), 64'(3'b1_01));
        chk("d2_no_branch", 64'({d2_pc_wr_cond, d2_branch_ne}), 64'(0));
        cyc(2);
        chk("d2_count_frozen", 64'(d2_count), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
